// File: rtl/if_id_hazard_ctrl.sv
// if_id_hazard_ctrl
// Sequences the PC register and the IF/ID pipeline register around load-use
// hazards, taken branches (with ",n" delay-slot nullification) and
// instruction-fetch wait states. It also drives the ID/EX bubble select and
// raises a sticky watchdog flag when the PC has been frozen for too long.
// Optional build macro: HAZ_PERF_CNT_EN adds three 32-bit performance counters.
module if_id_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int LOAD_LAT    = 1,
    parameter int WDOG_CYCLES = 255
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_br_taken,
    input  logic             ex_nullify,
    input  logic             imem_ready,
    output logic             pc_le,
    output logic             if_id_le,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       state,
    output logic             wdog_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      fetch_wait_cnt,
    output logic [31:0]      nullify_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        WAIT  = 2'b10
    } state_t;

    // LOAD_LAT never exceeds 4, so the remaining-stall count fits in 3 bits;
    // WDOG_CYCLES never exceeds 1023, so the watchdog fits in 10 bits.
    localparam int SCNT_W = 3;
    localparam int WCNT_W = 10;
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
    localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(LOAD_LAT - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(WDOG_CYCLES);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WDOG_CYCLES - 1);

    state_t            cur_state;
    state_t            next_state;
    logic [SCNT_W-1:0] scnt;
    logic [SCNT_W-1:0] next_scnt;
    logic [WCNT_W-1:0] wcnt;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              ld_use;
    logic              case_stall;
    logic              case_fetch;

    assign state = cur_state;

    // Hazard detection and selection of which priority case owns this cycle.
    always_comb begin
        rs1_hit    = id_rs1_used && (id_rs1 == ex_rd);
        rs2_hit    = id_rs2_used && (id_rs2 == ex_rd);
        ld_use     = ex_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
        case_stall = !ex_br_taken && ((cur_state == STALL) || ld_use);
        case_fetch = !ex_br_taken && !case_stall && !imem_ready;
    end

    // Zero-latency control outputs plus the next FSM state and stall count.
    always_comb begin
        pc_le        = 1'b1;
        if_id_le     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        next_state   = RUN;
        next_scnt    = '0;
        if (Reset) begin
            pc_le        = 1'b0;
            if_id_le     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (ex_br_taken) begin
            if_id_flush = ex_nullify;
        end else if (case_stall) begin
            pc_le        = 1'b0;
            if_id_le     = 1'b0;
            id_ex_bubble = 1'b1;
            if (cur_state == STALL) begin
                if (scnt != SCNT_ONE) begin
                    next_state = STALL;
                    next_scnt  = scnt - SCNT_ONE;
                end
            end else if (LOAD_LAT > 1) begin
                next_state = STALL;
                next_scnt  = SCNT_LOAD;
            end
        end else if (case_fetch) begin
            pc_le       = 1'b0;
            if_id_flush = 1'b1;
            next_state  = WAIT;
        end
    end

    // FSM state and remaining-stall counter.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cur_state <= RUN;
            scnt      <= '0;
        end else begin
            cur_state <= next_state;
            scnt      <= next_scnt;
        end
    end

    // Watchdog: count consecutive frozen-PC cycles and latch the error flag.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wcnt     <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (pc_le) begin
                wcnt <= '0;
            end else if (wcnt != WCNT_MAX) begin
                wcnt <= wcnt + WCNT_W'(1);
            end
            if (!pc_le && (wcnt >= WCNT_LAST)) begin
                wdog_err <= 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Performance counters; observation only, never fed back into control.
    always_ff @(posedge clk) begin
        if (Reset) begin
            stall_cnt      <= '0;
            fetch_wait_cnt <= '0;
            nullify_cnt    <= '0;
        end else begin
            if (case_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (case_fetch) begin
                fetch_wait_cnt <= fetch_wait_cnt + 32'd1;
            end
            if (ex_br_taken && ex_nullify) begin
                nullify_cnt <= nullify_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// tb_if_id_hazard_ctrl
// Drives two controller instances (LOAD_LAT=1/WDOG=255 and LOAD_LAT=3/WDOG=4)
// with shared directed and random stimulus and compares every output each
// cycle against a behavioural model built from "bubbles remaining" and
// "consecutive frozen cycles" bookkeeping. Honours HAZ_PERF_CNT_EN.
module tb_if_id_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int WDOG_A = 255;
    localparam int WDOG_B = 4;

    logic             clk = 1'b0;
    logic             Reset;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_rs1_used, id_rs2_used, ex_load;
    logic             ex_br_taken, ex_nullify, imem_ready;

    logic [1:0] pc_le_o, if_id_le_o, if_id_flush_o, id_ex_bubble_o, wdog_err_o;
    logic [1:0] state_o [2];
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_o [2];
    logic [31:0] fetch_wait_cnt_o [2];
    logic [31:0] nullify_cnt_o [2];
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state per instance
    int          m_left [2];
    bit          m_wait [2];
    int          m_consec [2];
    bit          m_err [2];
    int unsigned m_stall [2];
    int unsigned m_fetch [2];
    int unsigned m_null [2];

    always #5 clk = ~clk;

    if_id_hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(LAT_A), .WDOG_CYCLES(WDOG_A)) u_a (
        .clk(clk), .Reset(Reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_load(ex_load), .ex_rd(ex_rd),
        .ex_br_taken(ex_br_taken), .ex_nullify(ex_nullify), .imem_ready(imem_ready),
        .pc_le(pc_le_o[0]), .if_id_le(if_id_le_o[0]), .if_id_flush(if_id_flush_o[0]),
        .id_ex_bubble(id_ex_bubble_o[0]), .state(state_o[0]), .wdog_err(wdog_err_o[0])
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt_o[0]), .fetch_wait_cnt(fetch_wait_cnt_o[0]), .nullify_cnt(nullify_cnt_o[0])
`endif
    );

    if_id_hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(LAT_B), .WDOG_CYCLES(WDOG_B)) u_b (
        .clk(clk), .Reset(Reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_load(ex_load), .ex_rd(ex_rd),
        .ex_br_taken(ex_br_taken), .ex_nullify(ex_nullify), .imem_ready(imem_ready),
        .pc_le(pc_le_o[1]), .if_id_le(if_id_le_o[1]), .if_id_flush(if_id_flush_o[1]),
        .id_ex_bubble(id_ex_bubble_o[1]), .state(state_o[1]), .wdog_err(wdog_err_o[1])
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt_o[1]), .fetch_wait_cnt(fetch_wait_cnt_o[1]), .nullify_cnt(nullify_cnt_o[1])
`endif
    );

    // Single comparison point: counts it and reports a failure with $error
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void resetModel(input int i);
        m_left[i]   = 0;
        m_wait[i]   = 1'b0;
        m_consec[i] = 0;
        m_err[i]    = 1'b0;
        m_stall[i]  = 0;
        m_fetch[i]  = 0;
        m_null[i]   = 0;
    endfunction

    // Case that owns this cycle: 0 reset, 1 branch, 2 load-use stall, 3 fetch wait, 4 run
    function automatic int modelCase(input int i);
        bit hazard;
        hazard = ex_load && (ex_rd != 0) &&
                 ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        if (Reset) return 0;
        if (ex_br_taken) return 1;
        if (m_left[i] > 0 || hazard) return 2;
        if (!imem_ready) return 3;
        return 4;
    endfunction

    // Drive one cycle of inputs, check both instances, then advance the model
    task automatic applyStimulus(input logic rst, input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                                 input logic u1, input logic u2, input logic ld, input logic [REG_W-1:0] rd,
                                 input logic br, input logic nul, input logic rdy);
        int k [2];
        int lat, lim;
        bit pcle;
        Reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_load = ld; ex_rd = rd; ex_br_taken = br; ex_nullify = nul; imem_ready = rdy;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            string nm;
            logic [1:0] exp_state;
            nm = (i == 0) ? "a" : "b";
            k[i] = modelCase(i);
            pcle = (k[i] == 1 || k[i] == 4);
            exp_state = (m_left[i] > 0) ? 2'b01 : (m_wait[i] ? 2'b10 : 2'b00);
            checkOutput({nm, ".pc_le"}, 32'(pc_le_o[i]), 32'(pcle));
            checkOutput({nm, ".if_id_le"}, 32'(if_id_le_o[i]), 32'(k[i] == 1 || k[i] == 3 || k[i] == 4));
            checkOutput({nm, ".if_id_flush"}, 32'(if_id_flush_o[i]),
                        32'(k[i] == 0 || k[i] == 3 || (k[i] == 1 && nul)));
            checkOutput({nm, ".id_ex_bubble"}, 32'(id_ex_bubble_o[i]), 32'(k[i] == 0 || k[i] == 2));
            checkOutput({nm, ".state"}, 32'(state_o[i]), 32'(exp_state));
            checkOutput({nm, ".wdog_err"}, 32'(wdog_err_o[i]), 32'(m_err[i]));
`ifdef HAZ_PERF_CNT_EN
            checkOutput({nm, ".stall_cnt"}, stall_cnt_o[i], m_stall[i]);
            checkOutput({nm, ".fetch_wait_cnt"}, fetch_wait_cnt_o[i], m_fetch[i]);
            checkOutput({nm, ".nullify_cnt"}, nullify_cnt_o[i], m_null[i]);
`endif
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? LAT_A : LAT_B;
            lim = (i == 0) ? WDOG_A : WDOG_B;
            if (k[i] == 0) begin
                resetModel(i);
            end else begin
                pcle = (k[i] == 1 || k[i] == 4);
                case (k[i])
                    1: begin m_left[i] = 0; m_wait[i] = 1'b0; end
                    2: begin
                        if (m_left[i] > 0) m_left[i]--;
                        else m_left[i] = lat - 1;
                        m_wait[i] = 1'b0;
                        m_stall[i]++;
                    end
                    3: begin m_wait[i] = 1'b1; m_fetch[i]++; end
                    default: m_wait[i] = 1'b0;
                endcase
                if (br && nul) m_null[i]++;
                m_consec[i] = pcle ? 0 : m_consec[i] + 1;
                if (m_consec[i] >= lim) m_err[i] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        $display("[TB] start");
        Reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        ex_load = 0; ex_rd = '0; ex_br_taken = 0; ex_nullify = 0; imem_ready = 1;
        @(posedge clk);
        #1;
        resetModel(0);
        resetModel(1);

        // Reset held for two cycles, then release with imem ready
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        checkOutput("a.state_after_reset", 32'(state_o[0]), 32'd0);

        // Load-use on rs2 for one cycle, then the same pattern on GR0
        applyStimulus(0, 0, 5, 0, 1, 1, 5, 0, 0, 1);
        checkOutput("b.state_enter_stall", 32'(state_o[1]), 32'd1);
        idle(3);
        checkOutput("b.state_back_to_run", 32'(state_o[1]), 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        applyStimulus(0, 7, 0, 1, 0, 1, 7, 0, 0, 1);
        idle(3);

        // Taken branches with and without nullify, then a branch inside STALL
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 3, 0, 1, 0, 1, 3, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        checkOutput("b.stall_aborted", 32'(state_o[1]), 32'd0);
        idle(2);

        // Fetch wait for four cycles, then imem returns
        for (int c = 0; c < 4; c++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("b.wdog_err_set", 32'(wdog_err_o[1]), 32'd1);
        checkOutput("a.wdog_err_clear", 32'(wdog_err_o[0]), 32'd0);
        idle(2);
        checkOutput("b.wdog_err_sticky", 32'(wdog_err_o[1]), 32'd1);

        // Load-use arriving during a fetch wait
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 4, 0, 1, 0, 1, 4, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Reset in the middle of a stall
        applyStimulus(0, 2, 0, 1, 0, 1, 2, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Randomized traffic with small register numbers so hazards are frequent
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 9) < 4), REG_W'($urandom_range(0, 3)),
                          ($urandom_range(0, 99) < 15), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 99) < 75));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
